// File: rtl/vga_timing_pkg.sv
// 640x480 VGA timing constants and receiver state encoding.
package vga_timing_pkg;

  localparam int unsigned CW = 10;

  localparam int unsigned H_VIS        = 640;
  localparam int unsigned H_FP         = 16;
  localparam int unsigned H_SYNC       = 96;
  localparam int unsigned H_BP         = 48;
  localparam int unsigned H_SYNC_START = H_VIS + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned H_TOTAL      = H_SYNC_END + H_BP;

  localparam int unsigned V_VIS        = 480;
  localparam int unsigned V_FP         = 10;
  localparam int unsigned V_SYNC       = 2;
  localparam int unsigned V_BP         = 33;
  localparam int unsigned V_SYNC_START = V_VIS + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned V_TOTAL      = V_SYNC_END + V_BP;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    H_LOCK = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Registers a sync input twice and flags its leading/trailing edges.
module sync_edge_det #(
  parameter logic SYNC_ACTIVE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic lead_c,
  output logic trail_c
);

  logic s1;
  logic s2;

  // Both stages reset to the active level so a pulse already in flight at
  // reset release never looks like a fresh leading edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= SYNC_ACTIVE;
      s2 <= SYNC_ACTIVE;
    end else begin
      s1 <= sync_in;
      s2 <= s1;
    end
  end

  assign lead_c  = (s1 == SYNC_ACTIVE) && (s2 != SYNC_ACTIVE);
  assign trail_c = (s1 != SYNC_ACTIVE) && (s2 == SYNC_ACTIVE);

endmodule

// File: rtl/vga_rx.sv
// VGA stream receiver: locks to hsync/vsync and emits one beat per visible pixel.
module vga_rx
  import vga_timing_pkg::*;
#(
  parameter logic        SYNC_ACTIVE   = 1'b1,
  parameter int unsigned TIMEOUT_LINES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hsync,
  input  logic          vsync,
  input  logic [2:0]    rgb,
  output logic          pix_valid,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [2:0]    pix_rgb,
  output logic          frame_start,
  output logic          locked,
  output logic          sync_err
);

  localparam int unsigned TO_LIMIT = TIMEOUT_LINES * H_TOTAL;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

  rx_state_e       state;
  rx_state_e       state_next;
  logic            phase;
  logic            phase_next;
  logic [CW-1:0]   h_count;
  logic [CW-1:0]   v_count;
  logic [CW-1:0]   h_adv;
  logic [CW-1:0]   v_adv;
  logic [CW-1:0]   h_next;
  logic [CW-1:0]   v_next;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_next;
  logic [2:0]      rgb_r;
  logic            hs_lead_c;
  logic            hs_trail_c;
  logic            vs_lead_c;
  logic            vs_trail_c;
  logic            tick_c;
  logic            err_c;
  logic            vis_c;

  sync_edge_det #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_hs_det (
    .clk     (clk),
    .reset   (reset),
    .sync_in (hsync),
    .lead_c  (hs_lead_c),
    .trail_c (hs_trail_c)
  );

  sync_edge_det #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_vs_det (
    .clk     (clk),
    .reset   (reset),
    .sync_in (vsync),
    .lead_c  (vs_lead_c),
    .trail_c (vs_trail_c)
  );

  assign tick_c = !phase;

  // Free-running counters, edge reloads, timing checks and next state.
  always_comb begin
    h_adv      = h_count;
    v_adv      = v_count;
    to_next    = to_cnt;
    state_next = state;
    err_c      = 1'b0;
    vis_c      = 1'b0;

    if (tick_c) begin
      if (h_count == CW'(H_TOTAL - 1)) begin
        h_adv = '0;
        v_adv = (v_count == CW'(V_TOTAL - 1)) ? '0 : v_count + CW'(1);
      end else begin
        h_adv = h_count + CW'(1);
      end
    end

    // A leading edge lands where the free-running counters would have put
    // the second half of pixel 656, so the check is against the advanced values.
    h_next     = hs_lead_c ? CW'(H_SYNC_START) : h_adv;
    phase_next = hs_lead_c ? 1'b0 : !phase;
    v_next     = vs_lead_c ? CW'(V_SYNC_START) : v_adv;

    if (hs_lead_c) begin
      to_next = '0;
    end else if (tick_c && (to_cnt != TO_W'(TO_LIMIT - 1))) begin
      to_next = to_cnt + TO_W'(1);
    end

    if (state != SEARCH) begin
      err_c = (hs_lead_c && !((h_adv == CW'(H_SYNC_START)) && phase))
           || (hs_trail_c && (h_count != CW'(H_SYNC_END)))
           || (vs_lead_c && (state == LOCKED)
               && !((v_count == CW'(V_SYNC_START)) && (h_count == '0)))
           || (vs_trail_c && (v_count != CW'(V_SYNC_END)))
           || (tick_c && (to_cnt == TO_W'(TO_LIMIT - 1)));
    end

    unique case (state)
      SEARCH:  if (hs_lead_c) state_next = H_LOCK;
      H_LOCK:  if (vs_lead_c) state_next = LOCKED;
      LOCKED:  state_next = LOCKED;
      default: state_next = SEARCH;
    endcase
    if (err_c) state_next = SEARCH;

    vis_c = tick_c && (state == LOCKED)
         && (h_count < CW'(H_VIS)) && (v_count < CW'(V_VIS));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= SEARCH;
    else        state <= state_next;
  end

  // Pixel phase, coordinate counters, colour stage and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase       <= 1'b0;
      h_count     <= '0;
      v_count     <= '0;
      to_cnt      <= '0;
      rgb_r       <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      phase       <= phase_next;
      h_count     <= h_next;
      v_count     <= v_next;
      to_cnt      <= to_next;
      rgb_r       <= rgb;
      pix_valid   <= vis_c;
      frame_start <= vis_c && (h_count == '0) && (v_count == '0);
      locked      <= (state_next == LOCKED);
      sync_err    <= err_c;
      if (vis_c) begin
        pix_x   <= h_count;
        pix_y   <= v_count;
        pix_rgb <= rgb_r;
      end
    end
  end

endmodule

// File: tb/tb_vga_rx.sv
// Scoreboard bench for vga_rx: active-high and active-low instances on one stream.
module tb_vga_rx;

  typedef struct packed {
    logic [31:0] cyc;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  rgb;
    logic        fs;
  } beat_t;

  localparam int RUN_LIMIT = 70000;

  logic       clk = 1'b0;
  logic       reset;
  logic       hs_p, vs_p, hs_n, vs_n;
  logic [2:0] rgb;

  logic       pv_p, fs_p, lk_p, se_p;
  logic [9:0] px_p, py_p;
  logic [2:0] prgb_p;
  logic       pv_n, fs_n, lk_n, se_n;
  logic [9:0] px_n, py_n;
  logic [2:0] prgb_n;

  beat_t q[2][$];
  int    n_total = 0;
  int    n_bad   = 0;
  int    cyc     = 0;
  int    gx, gy, gsub;
  bit    hs_mute, hs_shift, vs_stretch, sb_en;
  int    errs[2], err_cyc[2], beats[2], fs_cnt[2];
  int    base[2];
  int    c_lead;

  always #5 clk = ~clk;

  vga_rx #(.SYNC_ACTIVE(1'b1), .TIMEOUT_LINES(2)) u_dut_p (
    .clk(clk), .reset(reset), .hsync(hs_p), .vsync(vs_p), .rgb(rgb),
    .pix_valid(pv_p), .pix_x(px_p), .pix_y(py_p), .pix_rgb(prgb_p),
    .frame_start(fs_p), .locked(lk_p), .sync_err(se_p)
  );

  vga_rx #(.SYNC_ACTIVE(1'b0), .TIMEOUT_LINES(2)) u_dut_n (
    .clk(clk), .reset(reset), .hsync(hs_n), .vsync(vs_n), .rgb(rgb),
    .pix_valid(pv_n), .pix_x(px_n), .pix_y(py_n), .pix_rgb(prgb_n),
    .frame_start(fs_n), .locked(lk_n), .sync_err(se_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive the sync/colour lines for the current generator pixel.
  task automatic drive();
    bit ha, va;
    ha = !hs_mute && (gx >= (hs_shift ? 657 : 656)) && (gx < 752);
    va = (gy >= 490) && (gy < (vs_stretch ? 493 : 492));
    hs_p = ha;  hs_n = !ha;
    vs_p = va;  vs_n = !va;
    rgb  = 3'(gx);
  endtask

  task automatic take_beat(input int k, input logic pv, input logic [9:0] x,
                           input logic [9:0] y, input logic [2:0] c, input logic fs);
    beat_t e;
    if (pv) begin
      beats[k]++;
      if (fs) fs_cnt[k]++;
      if (q[k].size() == 0) begin
        check($sformatf("beat%0d_unexpected", k), 32'(q[k].size()), 32'd1);
      end else begin
        e = q[k].pop_front();
        check($sformatf("beat%0d", k), {8'd0, x, y, c, fs}, {8'd0, e.x, e.y, e.rgb, e.fs});
        check($sformatf("lat%0d", k), 32'(cyc) - e.cyc, 32'd3);
      end
    end
  endtask

  // One clock: sample outputs at negedge, then advance the stream generator.
  task automatic step();
    beat_t e;
    @(negedge clk);
    cyc++;
    take_beat(0, pv_p, px_p, py_p, prgb_p, fs_p);
    take_beat(1, pv_n, px_n, py_n, prgb_n, fs_n);
    if (se_p) begin errs[0]++; err_cyc[0] = cyc; end
    if (se_n) begin errs[1]++; err_cyc[1] = cyc; end
    if (gsub == 1) begin
      gsub = 0;
      gx++;
      if (gx == 800) begin
        gx = 0;
        gy = (gy == 524) ? 0 : gy + 1;
      end
      if (sb_en && gx < 640 && gy < 480) begin
        e.cyc = 32'(cyc);
        e.x   = 10'(gx);
        e.y   = 10'(gy);
        e.rgb = 3'(gx);
        e.fs  = (gx == 0) && (gy == 0);
        q[0].push_back(e);
        q[1].push_back(e);
      end
    end else begin
      gsub = 1;
    end
    drive();
  endtask

  task automatic run_to(input int tx, input int ty);
    int n;
    n = 0;
    while (!(gx == tx && gy == ty && gsub == 0) && n < RUN_LIMIT) begin
      step();
      n++;
    end
    check($sformatf("reach_%0d_%0d", tx, ty), 32'(n < RUN_LIMIT), 32'd1);
  endtask

  task automatic expect_lock(input string tag, input logic exp);
    check({tag, "_p"}, 32'(lk_p), 32'(exp));
    check({tag, "_n"}, 32'(lk_n), 32'(exp));
  endtask

  initial begin
    reset = 1'b0;
    gx = 600; gy = 489; gsub = 0;
    hs_mute = 0; hs_shift = 0; vs_stretch = 0; sb_en = 0;
    for (int k = 0; k < 2; k++) begin
      errs[k] = 0; err_cyc[k] = 0; beats[k] = 0; fs_cnt[k] = 0;
    end
    drive();

    // Reset held with the stream running.
    repeat (10) step();
    check("rst_p", {pv_p, fs_p, lk_p, se_p, px_p, py_p, prgb_p}, 32'd0);
    check("rst_n", {pv_n, fs_n, lk_n, se_n, px_n, py_n, prgb_n}, 32'd0);
    reset = 1'b1;

    // Acquisition: locked rises the clock after the vsync leading edge.
    run_to(0, 490);
    step();
    expect_lock("lock_early", 1'b0);
    step();
    expect_lock("lock_up", 1'b1);
    check("acq_err_p", 32'(errs[0]), 32'd0);
    check("acq_err_n", 32'(errs[1]), 32'd0);

    // Vsync stretched to three lines: trailing edge at line 493 is an error.
    vs_stretch = 1;
    run_to(700, 493);
    check("vstretch_err_p", 32'(errs[0]), 32'd1);
    check("vstretch_err_n", 32'(errs[1]), 32'd1);
    expect_lock("vstretch_lock", 1'b0);
    vs_stretch = 0;
    gy = 489;
    run_to(0, 490);
    step();
    step();
    expect_lock("relock1", 1'b1);

    // Two hsync pulses missing: timeout 1600 ticks after the last leading edge.
    base[0] = errs[0]; base[1] = errs[1];
    run_to(656, 490);
    c_lead = cyc;
    run_to(0, 491);
    hs_mute = 1;
    run_to(0, 493);
    hs_mute = 0;
    check("tmo_err_p", 32'(errs[0] - base[0]), 32'd1);
    check("tmo_err_n", 32'(errs[1] - base[1]), 32'd1);
    check("tmo_at_p", 32'(err_cyc[0] - c_lead), 32'd3201);
    check("tmo_at_n", 32'(err_cyc[1] - c_lead), 32'd3201);
    expect_lock("tmo_lock", 1'b0);
    run_to(700, 493);
    gy = 489;
    run_to(0, 490);
    step();
    step();
    expect_lock("relock2", 1'b1);

    // Visible lines 0..2 through the scoreboard, then a late hsync in line 2.
    base[0] = errs[0]; base[1] = errs[1];
    sb_en = 1;
    run_to(0, 2);
    hs_shift = 1;
    run_to(640, 2);
    sb_en = 0;
    run_to(0, 3);
    hs_shift = 0;
    run_to(100, 3);
    check("shift_err_p", 32'(errs[0] - base[0]), 32'd1);
    check("shift_err_n", 32'(errs[1] - base[1]), 32'd1);
    expect_lock("shift_lock", 1'b0);
    check("left_p", 32'(q[0].size()), 32'd0);
    check("left_n", 32'(q[1].size()), 32'd0);
    check("beats_p", 32'(beats[0]), 32'd1920);
    check("beats_n", 32'(beats[1]), 32'd1920);
    check("fstart_p", 32'(fs_cnt[0]), 32'd1);
    check("fstart_n", 32'(fs_cnt[1]), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
